muldiv_unit: RTL and testbench

- Iterative sequencer for the unsigned multiply/divide resource (MULTU, DIVU) and the architectural HI/LO registers used by MFHI, MFLO, MTHI and MTLO.
- Sits beside the ALU in the single-cycle datapath. The decoder drives start/op and the register-file operands.
- Issues a stall to the processor when an MFHI/MFLO read arrives while an operation is still in flight.
- Multiply uses a shift-add algorithm; divide uses restoring division. Each retires one bit per cycle.

---
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_unit.sv | 112 +++++++++++
 tb/tb_muldiv_unit.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake/data bundle between the decoder/datapath and the multiply/divide unit.
// The master drives requests and operands; the slave returns status and HI/LO.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hilo_rd;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hilo_rd,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, hilo_rd,
        output busy, done, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU sequencer with architectural HI/LO registers.
// One result bit retires per cycle; MFHI/MFLO reads stall while busy.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    state_t            state_q;
    logic [CNTW-1:0]   cnt_q;
    logic              is_div_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  opb_q;
    logic [WIDTH-1:0]  wq_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_sh;
    logic [WIDTH-1:0]  div_diff;
    logic              div_ge;
    logic [WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]  wq_d;

    // acc holds the product high half (mul) or partial remainder (div);
    // wq holds the shifting multiplier/product low half or the quotient.
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (wq_q[0] ? {1'b0, opb_q} : '0);
        div_sh   = {acc_q, wq_q[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, opb_q};
        div_diff = div_sh[WIDTH-1:0] - opb_q;
        if (is_div_q) begin
            acc_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
            wq_d  = {wq_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = mul_sum[WIDTH:1];
            wq_d  = {mul_sum[0], wq_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            wq_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_RUN: begin
                    acc_q <= acc_d;
                    wq_q  <= wq_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        hi_q    <= acc_d;
                        lo_q    <= wq_d;
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_IDLE, S_FIN: begin
                    state_q <= S_IDLE;
                    if (bus.start) begin
                        unique case (bus.op)
                            OP_MULTU, OP_DIVU: begin
                                is_div_q <= bus.op[0];
                                acc_q    <= '0;
                                opb_q    <= bus.op[0] ? bus.b : bus.a;
                                wq_q     <= bus.op[0] ? bus.a : bus.b;
                                cnt_q    <= CNTW'(WIDTH - 1);
                                state_q  <= S_RUN;
                                busy_q   <= 1'b1;
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q & bus.hilo_rd;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random
// MULTU/DIVU/MTHI/MTLO traffic against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) m();

    muldiv_unit #(.WIDTH(32), .CNTW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m.slave)
    );

    function automatic void model(input logic [1:0] op,
                                  input logic [31:0] a, b);
        logic [63:0] p;
        case (op)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            2'd1: begin
                if (b == 0) begin
                    hi_m = a;
                    lo_m = 32'hFFFF_FFFF;
                end else begin
                    hi_m = a % b;
                    lo_m = a / b;
                end
            end
            2'd2: hi_m = a;
            default: lo_m = a;
        endcase
    endfunction

    // Issues one MULTU/DIVU and returns at the negedge of the FIN cycle.
    task automatic run_op(input logic [1:0] op_v,
                          input logic [31:0] av, bv,
                          input logic hrd, input int inj,
                          output int bcyc, output int scyc,
                          output bit held, output bit tmo);
        logic [31:0] h0, l0;
        int n;
        h0 = m.hi; l0 = m.lo;
        held = 1; bcyc = 0; scyc = 0; tmo = 0;
        m.start = 1; m.op = op_v; m.a = av; m.b = bv;
        m.hilo_rd = hrd;
        @(negedge clk);
        m.start = 0;
        m.op = 2'($urandom_range(3));
        m.a = $urandom; m.b = $urandom;
        n = 0;
        while (m.busy && n < 200) begin
            bcyc++;
            if (m.stall) scyc++;
            if (m.hi !== h0 || m.lo !== l0) held = 0;
            if (n == inj) begin
                m.start = 1; m.op = 2'd0; m.a = 7; m.b = 7;
            end else m.start = 0;
            @(negedge clk);
            n++;
        end
        m.start = 0;
        if (n >= 200) tmo = 1;
    endtask

    task automatic issue_mt(input logic [1:0] op_v,
                            input logic [31:0] av);
        m.start = 1; m.op = op_v; m.a = av; m.b = $urandom;
        @(negedge clk);
        m.start = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({m.hi, m.lo} !== 64'd0 ||
            {m.busy, m.done, m.stall} !== 3'b000) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h b/d/s=%b%b%b exp 0",
                     m.hi, m.lo, m.busy, m.done, m.stall);
        end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_multu();
        int bc, sc; bit hd, to;
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            b = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            run_op(2'd0, a, b, 1'b0, -1, bc, sc, hd, to);
            model(2'd0, a, b);
            checks++;
            if (to || bc != 32 || !hd) begin
                errors++;
                $display("FAIL multu_busy: cyc=%0d held=%0b exp 32/1",
                         bc, hd);
            end
            checks++;
            if (m.hi !== hi_m || m.lo !== lo_m || m.done !== 1'b1) begin
                errors++;
                $display("FAIL multu %h*%h: %h_%h done=%b exp %h_%h",
                         a, b, m.hi, m.lo, m.done, hi_m, lo_m);
            end
            @(negedge clk);
            checks++;
            if (m.done !== 1'b0) begin
                errors++;
                $display("FAIL multu_done_pulse: done=%b exp 0", m.done);
            end
        end
    endtask

    task automatic test_divu();
        int bc, sc; bit hd, to;
        run_op(2'd1, 32'd100, 32'd7, 1'b0, -1, bc, sc, hd, to);
        model(2'd1, 32'd100, 32'd7);
        checks++;
        if (to || bc != 32 || !hd || m.lo !== 32'd14 ||
            m.hi !== 32'd2 || hi_m !== 32'd2) begin
            errors++;
            $display("FAIL divu 100/7: q=%0d r=%0d cyc=%0d held=%0b exp 14/2/32/1",
                     m.lo, m.hi, bc, hd);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int bc, sc; bit hd, to;
        run_op(2'd1, 32'h1234, 32'd0, 1'b1, -1, bc, sc, hd, to);
        model(2'd1, 32'h1234, 32'd0);
        checks++;
        if (to || bc != 32 || sc != 32 || m.stall !== 1'b0) begin
            errors++;
            $display("FAIL div0_timing: cyc=%0d stall=%0d fin_stall=%b exp 32/32/0",
                     bc, sc, m.stall);
        end
        checks++;
        if (m.lo !== lo_m || m.hi !== hi_m) begin
            errors++;
            $display("FAIL div0: lo=%h hi=%h exp %h %h",
                     m.lo, m.hi, lo_m, hi_m);
        end
        m.hilo_rd = 0;
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int bc, sc; bit hd, to;
        run_op(2'd0, 32'd3, 32'd5, 1'b1, 10, bc, sc, hd, to);
        model(2'd0, 32'd3, 32'd5);
        checks++;
        if (to || bc != 32 || sc != 32 || m.stall !== 1'b0) begin
            errors++;
            $display("FAIL busy_stall: cyc=%0d stall=%0d fin=%b exp 32/32/0",
                     bc, sc, m.stall);
        end
        checks++;
        if (m.hi !== 32'd0 || m.lo !== 32'd15) begin
            errors++;
            $display("FAIL busy_ignore: hi=%h lo=%h exp 0 15", m.hi, m.lo);
        end
        @(negedge clk);
        checks++;
        if (m.busy !== 1'b0 || m.stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_stall: busy=%b stall=%b exp 0 0",
                     m.busy, m.stall);
        end
        m.hilo_rd = 0;
    endtask

    task automatic test_mt();
        issue_mt(2'd2, 32'hDEAD_BEEF);
        model(2'd2, 32'hDEAD_BEEF, 0);
        checks++;
        if (m.hi !== 32'hDEAD_BEEF || m.lo !== lo_m ||
            m.busy !== 1'b0 || m.done !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h b=%b d=%b exp %h %h 0 0",
                     m.hi, m.lo, m.busy, m.done, hi_m, lo_m);
        end
        issue_mt(2'd3, 32'h0BAD_F00D);
        model(2'd3, 32'h0BAD_F00D, 0);
        checks++;
        if (m.lo !== 32'h0BAD_F00D || m.hi !== 32'hDEAD_BEEF ||
            m.busy !== 1'b0 || m.done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h b=%b d=%b exp %h %h 0 0",
                     m.hi, m.lo, m.busy, m.done, hi_m, lo_m);
        end
    endtask

    task automatic test_back_to_back();
        int bc, sc; bit hd, to;
        logic [31:0] a, b;
        a = $urandom; b = $urandom_range(1000, 1);
        run_op(2'd1, a, b, 1'b0, -1, bc, sc, hd, to);
        model(2'd1, a, b);
        run_op(2'd0, a, b, 1'b0, -1, bc, sc, hd, to);
        model(2'd0, a, b);
        checks++;
        if (to || bc != 32 || !hd || m.hi !== hi_m || m.lo !== lo_m) begin
            errors++;
            $display("FAIL b2b: cyc=%0d held=%0b %h_%h exp %h_%h",
                     bc, hd, m.hi, m.lo, hi_m, lo_m);
        end
        issue_mt(2'd2, 32'h1357_9BDF);
        model(2'd2, 32'h1357_9BDF, 0);
        checks++;
        if (m.hi !== hi_m || m.lo !== lo_m ||
            m.busy !== 1'b0 || m.done !== 1'b0) begin
            errors++;
            $display("FAIL mthi_in_fin: %h_%h b=%b d=%b exp %h_%h",
                     m.hi, m.lo, m.busy, m.done, hi_m, lo_m);
        end
    endtask

    task automatic test_reset_mid();
        int bc, sc; bit hd, to;
        issue_mt(2'd2, 32'h55);
        issue_mt(2'd3, 32'hAA);
        m.start = 1; m.op = 2'd1; m.a = 32'd1000; m.b = 32'd3;
        @(negedge clk);
        m.start = 0;
        repeat (14) @(negedge clk);
        #2 reset = 1;
        #1;
        checks++;
        if ({m.hi, m.lo} !== 64'd0 ||
            {m.busy, m.done, m.stall} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: hi=%h lo=%h b/d/s=%b%b%b exp 0",
                     m.hi, m.lo, m.busy, m.done, m.stall);
        end
        #1 reset = 0;
        hi_m = 0; lo_m = 0;
        @(negedge clk);
        run_op(2'd0, 32'd6, 32'd7, 1'b0, -1, bc, sc, hd, to);
        checks++;
        if (to || bc != 32 || m.lo !== 32'd42 || m.hi !== 32'd0) begin
            errors++;
            $display("FAIL after_reset: cyc=%0d hi=%h lo=%h exp 32 0 42",
                     bc, m.hi, m.lo);
        end
        model(2'd0, 32'd6, 32'd7);
        @(negedge clk);
    endtask

    task automatic test_random();
        int bc, sc; bit hd, to;
        logic [1:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(3));
            a = $urandom;
            case ($urandom_range(3))
                0: b = 0;
                1: b = $urandom_range(16, 1);
                default: b = $urandom;
            endcase
            if (op[1]) issue_mt(op, a);
            else run_op(op, a, b, 1'($urandom_range(1)), -1,
                        bc, sc, hd, to);
            model(op, a, b);
            checks++;
            if (m.hi !== hi_m || m.lo !== lo_m ||
                (!op[1] && (to || bc != 32 || !hd))) begin
                errors++;
                $display("FAIL rand op=%0d a=%h b=%h: %h_%h exp %h_%h",
                         op, a, b, m.hi, m.lo, hi_m, lo_m);
            end
            m.hilo_rd = 0;
            if ($urandom_range(1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        m.start = 0; m.op = 0; m.a = 0; m.b = 0; m.hilo_rd = 0;
        test_reset();
        test_multu();
        test_divu();
        test_div_zero();
        test_busy_ignore();
        test_mt();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
